// File: rtl/spi_pkg.sv
// Shared state encoding and default parameters for the SPI slave endpoint.
// No logic: types and constants only, so it adds no latency and has no backpressure.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT
    } state_e;

    localparam int         DEF_DATA_WIDTH  = 8;
    localparam int         DEF_SYNC_STAGES = 2;
    localparam logic [7:0] DEF_IDLE_WORD   = 8'hFF;

endpackage

// File: rtl/spi_slave_core_if.sv
// Host-side transmit/receive handshake of the SPI slave endpoint.
// Wiring only: no latency; valid/ready on both TX and RX paths.
interface spi_slave_core_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] I_TX_DATA;
    logic                  I_TX_VALID;
    logic                  O_TX_READY;
    logic [DATA_WIDTH-1:0] O_RX_DATA;
    logic                  O_RX_VALID;
    logic                  I_RX_READY;
    logic                  O_OVERRUN;
    logic                  I_CLR_ERR;
    logic                  O_FRAME_ERR;
    logic                  O_BUSY;

    modport slave (
        input  I_TX_DATA, I_TX_VALID, I_RX_READY, I_CLR_ERR,
        output O_TX_READY, O_RX_DATA, O_RX_VALID, O_OVERRUN, O_FRAME_ERR, O_BUSY
    );

    modport master (
        output I_TX_DATA, I_TX_VALID, I_RX_READY, I_CLR_ERR,
        input  O_TX_READY, O_RX_DATA, O_RX_VALID, O_OVERRUN, O_FRAME_ERR, O_BUSY
    );
endinterface

// File: rtl/spi_sync.sv
// N-stage single-bit synchroniser with a configurable reset preset.
// Latency STAGES clocks; no backpressure.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];
endmodule

// File: rtl/spi_slave_core.sv
// SPI mode-0 slave: oversampled deserialiser/serialiser; SPI_SLAVE_ECHO_EN echoes the last RX word.
// RX valid SYNC_STAGES+2 clocks after last SCLK rise; no RX backpressure on the wire, overrun flagged.
module spi_slave_core
    import spi_pkg::*;
#(
    parameter int                    DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int                    SYNC_STAGES = DEF_SYNC_STAGES,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = DATA_WIDTH'(DEF_IDLE_WORD)
) (
    input  logic               I_CLK,
    input  logic               I_RESETN,
    input  logic               SCLK_SLAVE,
    input  logic               SS_N_SLAVE,
    input  logic               MOSI_SLAVE,
    output logic               MISO_SLAVE,
    output logic               MISO_OE,
    spi_slave_core_if.slave    host
);
    localparam int                CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam int                SET_W    = $clog2(SYNC_STAGES + 3) + 1;
    localparam logic [SET_W-1:0]  SETTLE   = SET_W'(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic sclk_s, ss_n_s, mosi_s;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(I_CLK), .rst_n(I_RESETN), .d(SCLK_SLAVE), .q(sclk_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss_n (
        .clk(I_CLK), .rst_n(I_RESETN), .d(SS_N_SLAVE), .q(ss_n_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(I_CLK), .rst_n(I_RESETN), .d(MOSI_SLAVE), .q(mosi_s));

    state_e                state_q, state_d;
    logic                  sclk_prev_q, ss_n_prev_q;
    logic [SET_W-1:0]      settle_q, settle_d;
    logic [DATA_WIDTH-1:0] shout_q, shout_d;
    logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  reload_q, reload_d;
    logic                  commit_q, commit_d;
    logic                  tx_full_q, tx_full_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  rx_valid_q, rx_valid_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  ovr_q, ovr_d;
    logic                  frame_err_q, frame_err_d;
    logic                  take_tx;
    logic                  settled, sclk_rise, sclk_fall, ss_fall, ss_rise;
    logic [DATA_WIDTH-1:0] fill_word, next_word;

`ifdef SPI_SLAVE_ECHO_EN
    logic [DATA_WIDTH-1:0] echo_q, echo_d;

    always_comb begin
        echo_d = echo_q;
        if (commit_q) begin
            echo_d = rx_sh_q;
        end
    end

    always_ff @(posedge I_CLK or negedge I_RESETN) begin
        if (!I_RESETN) begin
            echo_q <= IDLE_WORD;
        end else begin
            echo_q <= echo_d;
        end
    end

    assign fill_word = echo_q;
`else
    assign fill_word = IDLE_WORD;
`endif

    // The SS_N preset makes a held-low pin look like a fall once the synchroniser fills;
    // ignoring falls until the pipeline settles keeps a mid-frame reset from re-entering the frame.
    assign settled   = (settle_q == SETTLE);
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign ss_fall   = ~ss_n_s & ss_n_prev_q & settled;
    assign ss_rise   = ss_n_s & ~ss_n_prev_q;
    assign next_word = tx_full_q ? hold_q : fill_word;

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        shout_d     = shout_q;
        rx_sh_d     = rx_sh_q;
        bit_cnt_d   = bit_cnt_q;
        reload_d    = reload_q;
        commit_d    = 1'b0;
        frame_err_d = 1'b0;
        take_tx     = 1'b0;
        tx_full_d   = tx_full_q;
        hold_d      = hold_q;
        rx_valid_d  = rx_valid_q;
        rx_data_d   = rx_data_q;
        ovr_d       = ovr_q & ~host.I_CLR_ERR;

        if (!settled) begin
            settle_d = settle_q + SET_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (ss_fall) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                shout_d   = next_word;
                take_tx   = tx_full_q;
                bit_cnt_d = '0;
                reload_d  = 1'b0;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (ss_rise) begin
                    state_d     = ST_IDLE;
                    frame_err_d = (bit_cnt_q != '0);
                    bit_cnt_d   = '0;
                    reload_d    = 1'b0;
                end else if (sclk_rise) begin
                    rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], mosi_s};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        commit_d  = 1'b1;
                        reload_d  = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sclk_fall) begin
                    if (reload_q) begin
                        shout_d  = next_word;
                        take_tx  = tx_full_q;
                        reload_d = 1'b0;
                    end else begin
                        shout_d = {shout_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A write only lands while empty, so it can never collide with the holding register being taken.
        if (take_tx) begin
            tx_full_d = 1'b0;
        end
        if (host.I_TX_VALID && !tx_full_q) begin
            tx_full_d = 1'b1;
            hold_d    = host.I_TX_DATA;
        end

        if (rx_valid_q && host.I_RX_READY) begin
            rx_valid_d = 1'b0;
        end
        if (commit_q) begin
            if (!rx_valid_q || host.I_RX_READY) begin
                rx_data_d  = rx_sh_q;
                rx_valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge I_CLK or negedge I_RESETN) begin
        if (!I_RESETN) begin
            state_q     <= ST_IDLE;
            sclk_prev_q <= 1'b0;
            ss_n_prev_q <= 1'b1;
            settle_q    <= '0;
            shout_q     <= '1;
            rx_sh_q     <= '0;
            bit_cnt_q   <= '0;
            reload_q    <= 1'b0;
            commit_q    <= 1'b0;
            tx_full_q   <= 1'b0;
            hold_q      <= '0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            ovr_q       <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_prev_q <= sclk_s;
            ss_n_prev_q <= ss_n_s;
            settle_q    <= settle_d;
            shout_q     <= shout_d;
            rx_sh_q     <= rx_sh_d;
            bit_cnt_q   <= bit_cnt_d;
            reload_q    <= reload_d;
            commit_q    <= commit_d;
            tx_full_q   <= tx_full_d;
            hold_q      <= hold_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            ovr_q       <= ovr_d;
            frame_err_q <= frame_err_d;
        end
    end

    // During LOAD the MSB comes straight from the mux so MISO is valid before the register settles.
    assign MISO_SLAVE = (state_q == ST_IDLE) ? 1'b1 :
                        (state_q == ST_LOAD) ? next_word[DATA_WIDTH-1] :
                                               shout_q[DATA_WIDTH-1];
    assign MISO_OE          = (state_q != ST_IDLE);
    assign host.O_BUSY      = (state_q != ST_IDLE);
    assign host.O_TX_READY  = ~tx_full_q;
    assign host.O_RX_DATA   = rx_data_q;
    assign host.O_RX_VALID  = rx_valid_q;
    assign host.O_OVERRUN   = ovr_q;
    assign host.O_FRAME_ERR = frame_err_q;
endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: SPI mode-0 master model plus an RX scoreboard.
// Received words are queued at stimulus time and checked by a monitor on each RX handshake.
module tb_spi_slave_core;
`ifdef SPI_SLAVE_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic sclk, ss_n, mosi;
    logic miso, miso_oe;

    int checks = 0;
    int errors = 0;
    int ferr_cnt = 0;
    logic [7:0] exp_q[$];

    spi_slave_core_if #(.DATA_WIDTH(8)) host ();

    spi_slave_core dut (
        .I_CLK      (clk),
        .I_RESETN   (rst_n),
        .SCLK_SLAVE (sclk),
        .SS_N_SLAVE (ss_n),
        .MOSI_SLAVE (mosi),
        .MISO_SLAVE (miso),
        .MISO_OE    (miso_oe),
        .host       (host)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = tx[i];
            tick(4);
            rx[i] = miso;
            sclk = 1'b1;
            tick(4);
            sclk = 1'b0;
        end
    endtask

    task automatic frame_begin();
        ss_n = 1'b0;
        tick(6);
    endtask

    task automatic frame_end();
        tick(4);
        ss_n = 1'b1;
        tick(10);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_miso"},      miso, 1'b1);
        chk({tag, "_miso_oe"},   miso_oe, 1'b0);
        chk({tag, "_tx_ready"},  host.O_TX_READY, 1'b1);
        chk({tag, "_rx_data"},   host.O_RX_DATA, 8'h00);
        chk({tag, "_rx_valid"},  host.O_RX_VALID, 1'b0);
        chk({tag, "_overrun"},   host.O_OVERRUN, 1'b0);
        chk({tag, "_frame_err"}, host.O_FRAME_ERR, 1'b0);
        chk({tag, "_busy"},      host.O_BUSY, 1'b0);
    endtask

    // Scoreboard monitor: every accepted RX word must match the oldest expected word.
    always @(negedge clk) begin : mon
        logic [7:0] e;
        if (rst_n && host.O_RX_VALID && host.I_RX_READY) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got %h expected no word", host.O_RX_DATA);
            end else begin
                e = exp_q.pop_front();
                chk("rx_data", host.O_RX_DATA, e);
            end
        end
        if (host.O_FRAME_ERR) ferr_cnt++;
    end

    initial begin
        logic [7:0] r;
        int f0;
        int waited;

        rst_n = 1'b0;
        sclk = 1'b0;
        ss_n = 1'b1;
        mosi = 1'b0;
        host.I_TX_DATA  = 8'h00;
        host.I_TX_VALID = 1'b0;
        host.I_RX_READY = 1'b1;
        host.I_CLR_ERR  = 1'b0;
        tick(3);
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        tick(8);

        // TX load A5, receive 3C; a second write while full is ignored
        host.I_TX_DATA  = 8'hA5;
        host.I_TX_VALID = 1'b1;
        tick(1);
        host.I_TX_DATA  = 8'h99;
        tick(1);
        host.I_TX_VALID = 1'b0;
        chk("tx_ready_after_write", host.O_TX_READY, 1'b0);
        exp_q.push_back(8'h3C);
        frame_begin();
        chk("busy_in_frame", host.O_BUSY, 1'b1);
        chk("miso_oe_in_frame", miso_oe, 1'b1);
        chk("tx_ready_after_load", host.O_TX_READY, 1'b1);
        xfer(8'h3C, 8, r);
        chk("miso_word_a5", r, 8'hA5);
        frame_end();
        chk("busy_after_frame", host.O_BUSY, 1'b0);

        // two back-to-back words, no TX load
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        frame_begin();
        xfer(8'h11, 8, r);
        chk("miso_b2b_w0", r, ECHO ? 8'h3C : 8'hFF);
        xfer(8'h22, 8, r);
        chk("miso_b2b_w1", r, ECHO ? 8'h11 : 8'hFF);
        frame_end();
        chk("no_overrun_b2b", host.O_OVERRUN, 1'b0);

        // overrun with consumer stalled
        host.I_RX_READY = 1'b0;
        frame_begin();
        xfer(8'h81, 8, r);
        chk("miso_ovr_w0", r, ECHO ? 8'h22 : 8'hFF);
        xfer(8'h42, 8, r);
        chk("miso_ovr_w1", r, ECHO ? 8'h81 : 8'hFF);
        frame_end();
        chk("ovr_rx_data_kept", host.O_RX_DATA, 8'h81);
        chk("ovr_rx_valid", host.O_RX_VALID, 1'b1);
        chk("ovr_flag_set", host.O_OVERRUN, 1'b1);
        tick(5);
        chk("ovr_flag_sticky", host.O_OVERRUN, 1'b1);
        host.I_CLR_ERR = 1'b1;
        tick(1);
        host.I_CLR_ERR = 1'b0;
        chk("ovr_flag_cleared", host.O_OVERRUN, 1'b0);
        exp_q.push_back(8'h81);
        host.I_RX_READY = 1'b1;
        tick(3);
        chk("rx_valid_drained", host.O_RX_VALID, 1'b0);

        // SS_N raised after 5 bits
        f0 = ferr_cnt;
        frame_begin();
        xfer(8'hF0, 5, r);
        frame_end();
        chk("frame_err_pulses", ferr_cnt - f0, 1);
        chk("frame_err_no_valid", host.O_RX_VALID, 1'b0);
        exp_q.push_back(8'h5A);
        frame_begin();
        xfer(8'h5A, 8, r);
        chk("miso_after_ferr", r, ECHO ? 8'h42 : 8'hFF);
        frame_end();

        // reset mid-frame, slave ignores the rest of that frame
        frame_begin();
        xfer(8'hAA, 3, r);
        rst_n = 1'b0;
        tick(2);
        chk_reset_outputs("midrst");
        rst_n = 1'b1;
        tick(10);
        f0 = ferr_cnt;
        xfer(8'hAA, 5, r);
        chk("busy_after_midrst", host.O_BUSY, 1'b0);
        chk("miso_oe_after_midrst", miso_oe, 1'b0);
        frame_end();
        chk("no_ferr_after_midrst", ferr_cnt - f0, 0);
        chk("no_valid_after_midrst", host.O_RX_VALID, 1'b0);
        exp_q.push_back(8'hC3);
        frame_begin();
        xfer(8'hC3, 8, r);
        chk("miso_after_midrst", r, 8'hFF);
        frame_end();

        // idle fill: IDLE_WORD, or the last received word when echo is built in
        exp_q.push_back(8'h7E);
        exp_q.push_back(8'h00);
        frame_begin();
        xfer(8'h7E, 8, r);
        chk("miso_fill_0", r, ECHO ? 8'hC3 : 8'hFF);
        frame_end();
        frame_begin();
        xfer(8'h00, 8, r);
        chk("miso_fill_1", r, ECHO ? 8'h7E : 8'hFF);
        frame_end();

        waited = 0;
        while (exp_q.size() != 0 && waited < 200) begin
            tick(1);
            waited++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
